// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction-memory port arbiter.
package imem_pkg;

  localparam int ADDR_W_DEF     = 13;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  // Ownership phase of the memory port: loader-only boot, or fetch-priority run.
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bits needed to hold a starvation count of 0..max.
  function automatic int starve_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Counts consecutive cycles a pending loader write has been denied.
module imem_starve_ctr
  import imem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  localparam int CW        = starve_w(STARVE_MAX)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [CW-1:0] cnt_reg;

  // Clear dominates increment so a boot entry or a grant always restarts the count.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // The loader is forced through once it has waited the full budget.
  assign at_max = (cnt_reg == CW'(STARVE_MAX));

endmodule

// File: rtl/imem_port_arbiter.sv
// Single-port instruction-memory arbiter: loader owns the port during boot,
// fetch has priority during run with a bounded wait for late loader writes.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_inst,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_gnt,
  input  logic              load_done,
  input  logic              boot_req,
  output logic              running,
  output logic [ADDR_W:0]   load_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t          state_reg;
  state_t          state_next;
  logic            running_reg;
  logic            fetch_valid_reg;
  logic [ADDR_W:0] load_count_reg;
  logic            starve_inc;
  logic            starve_clr;
  logic            starve_at_max;
  logic            count_clr;

  imem_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .reset  (reset),
    .clr    (starve_clr),
    .inc    (starve_inc),
    .at_max (starve_at_max)
  );

  // Phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grant decision and phase transitions; reset suppresses every grant.
  always_comb begin
    state_next = state_reg;
    fetch_gnt  = 1'b0;
    load_gnt   = 1'b0;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    count_clr  = 1'b0;
    if (!reset) begin
      unique case (state_reg)
        BOOT: begin
          load_gnt   = load_req;
          starve_clr = 1'b1;
          if (load_done) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (load_req && starve_at_max) begin
            load_gnt = 1'b1;
          end else begin
            fetch_gnt = fetch_req;
            load_gnt  = load_req & ~fetch_req;
          end
          starve_inc = load_req & ~load_gnt;
          starve_clr = ~load_req | load_gnt;
          // Grants this cycle still follow run rules; bookkeeping restarts in boot.
          if (boot_req) begin
            state_next = BOOT;
            starve_clr = 1'b1;
            count_clr  = 1'b1;
          end
        end
        default: state_next = BOOT;
      endcase
    end
  end

  // Registered status: run flag and read-data valid one cycle after a fetch grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      running_reg     <= 1'b0;
      fetch_valid_reg <= 1'b0;
    end else begin
      running_reg     <= (state_next == RUN);
      fetch_valid_reg <= fetch_gnt;
    end
  end

  // Granted-write counter, saturating at the full address-space size.
  always_ff @(posedge clk) begin
    if (reset || count_clr) begin
      load_count_reg <= '0;
    end else if (load_gnt && (load_count_reg != COUNT_MAX)) begin
      load_count_reg <= load_count_reg + 1'b1;
    end
  end

  // Memory port mux; idle cycles drive zeros so the array sees no stray address.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (load_gnt) begin
      mem_addr  = load_addr;
      mem_we    = 1'b1;
      mem_wdata = load_data;
    end else if (fetch_gnt) begin
      mem_addr  = fetch_addr;
    end
  end

  assign running     = running_reg;
  assign fetch_valid = fetch_valid_reg;
  assign fetch_inst  = fetch_valid_reg ? mem_rdata : '0;
  assign load_count  = load_count_reg;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter with an external RAM and a cycle reference model.
module tb_imem_port_arbiter;

  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_inst;
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_gnt;
  logic              load_done;
  logic              boot_req;
  logic              running;
  logic [ADDR_W:0]   load_count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  imem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_gnt(load_gnt), .load_done(load_done), .boot_req(boot_req),
    .running(running), .load_count(load_count),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External synchronous-read instruction memory.
  logic [DATA_W-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: ownership flag, consecutive-denial count, write tally, ideal memory.
  logic              m_run;
  int                m_wait;
  int                m_count;
  logic              m_valid;
  logic [DATA_W-1:0] m_inst;
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic              exp_fg;
  logic              exp_lg;

  always_comb begin
    exp_fg = 1'b0;
    exp_lg = 1'b0;
    if (!reset) begin
      if (!m_run) exp_lg = load_req;
      else if (load_req && m_wait >= STARVE_MAX) exp_lg = 1'b1;
      else begin
        exp_fg = fetch_req;
        exp_lg = load_req && !fetch_req;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_run <= 1'b0; m_wait <= 0; m_count <= 0; m_valid <= 1'b0; m_inst <= '0;
    end else begin
      m_valid <= exp_fg;
      m_inst  <= exp_fg ? ref_mem[fetch_addr] : '0;
      if (exp_lg) ref_mem[load_addr] <= load_data;
      m_wait  <= (m_run && load_req && !exp_lg) ? m_wait + 1 : 0;
      if (m_run && boot_req) m_count <= 0;
      else if (exp_lg && m_count < DEPTH) m_count <= m_count + 1;
      if (!m_run && load_done) m_run <= 1'b1;
      else if (m_run && boot_req) m_run <= 1'b0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; load_req = 1'b0; load_done = 1'b0; boot_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_req = 1'b1; fetch_addr = '0;
    load_req = 1'b1; load_addr = 13'd5; load_data = 32'hdeadbeef;
    load_done = 1'b0; boot_req = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (fetch_gnt !== 1'b0 || load_gnt !== 1'b0) begin failures++; $display("FAIL reset_grants got fg=%b lg=%b exp 0 0", fetch_gnt, load_gnt); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (running !== 1'b0 || fetch_valid !== 1'b0 || load_count !== '0 || fetch_inst !== '0) begin failures++; $display("FAIL reset_regs got run=%b fv=%b cnt=%0d inst=%h exp zeros", running, fetch_valid, load_count, fetch_inst); end
    next_cycle();
    reset = 1'b0; load_req = 1'b0; fetch_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (fetch_gnt !== 1'b0 || running !== 1'b0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL boot_blocks_fetch cyc=%0d got fg=%b run=%b fv=%b exp 0 0 0", i, fetch_gnt, running, fetch_valid); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_boot_load();
    logic [DATA_W-1:0] prog [3];
    prog[0] = 32'h20080005; prog[1] = 32'h20090003; prog[2] = 32'h01095020;
    for (int i = 0; i < 3; i++) begin
      load_req = 1'b1; load_addr = ADDR_W'(i); load_data = prog[i]; load_done = (i == 2);
      @(negedge clk);
      $display("write addr=%0d data=%h gnt=%b", i, mem_wdata, load_gnt);
      checks++; if (load_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(i) || mem_wdata !== prog[i]) begin failures++; $display("FAIL boot_write%0d got lg=%b we=%b a=%0d d=%h exp 1 1 %0d %h", i, load_gnt, mem_we, mem_addr, mem_wdata, i, prog[i]); end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (running !== 1'b1 || load_count !== 14'd3) begin failures++; $display("FAIL boot_done got run=%b cnt=%0d exp 1 3", running, load_count); end
    for (int k = 0; k < 4; k++) begin
      fetch_req = (k < 3); fetch_addr = ADDR_W'(k % 3);
      @(negedge clk);
      if (k < 3) begin
        checks++; if (fetch_gnt !== 1'b1) begin failures++; $display("FAIL fetch_gnt%0d got %b exp 1", k, fetch_gnt); end
      end
      if (k > 0) begin
        $display("fetch addr=%0d inst=%h valid=%b", k - 1, fetch_inst, fetch_valid);
        checks++; if (fetch_valid !== 1'b1 || fetch_inst !== prog[k-1]) begin failures++; $display("FAIL fetch_data%0d got v=%b inst=%h exp 1 %h", k - 1, fetch_valid, fetch_inst, prog[k-1]); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_starve();
    logic e;
    fetch_req = 1'b1; fetch_addr = 13'd1; load_req = 1'b1; load_addr = 13'd100; load_data = $urandom;
    for (int k = 0; k < 15; k++) begin
      e = ((k % 5) == 4);
      @(negedge clk);
      checks++; if (load_gnt !== e || fetch_gnt !== !e) begin failures++; $display("FAIL starve cyc=%0d got lg=%b fg=%b exp %b %b", k, load_gnt, fetch_gnt, e, !e); end
      next_cycle();
      if (e) load_data = $urandom;
    end
    idle_inputs();
  endtask

  task automatic test_load_idle();
    logic e;
    for (int k = 0; k < 3; k++) begin
      load_req = 1'b1; load_addr = ADDR_W'(101 + k); load_data = $urandom;
      @(negedge clk);
      checks++; if (load_gnt !== 1'b1 || mem_we !== 1'b1 || fetch_gnt !== 1'b0 || mem_addr !== load_addr) begin failures++; $display("FAIL idle_load%0d got lg=%b we=%b fg=%b a=%0d exp 1 1 0 %0d", k, load_gnt, mem_we, fetch_gnt, mem_addr, load_addr); end
      next_cycle();
    end
    fetch_req = 1'b1; fetch_addr = 13'd2; load_addr = 13'd104;
    for (int k = 0; k < 5; k++) begin
      e = (k == 4);
      @(negedge clk);
      checks++; if (load_gnt !== e) begin failures++; $display("FAIL idle_starve_start cyc=%0d got lg=%b exp %b", k, load_gnt, e); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_boot_req();
    fetch_req = 1'b1; fetch_addr = 13'd0; boot_req = 1'b1;
    @(negedge clk);
    checks++; if (fetch_gnt !== 1'b1 || running !== 1'b1) begin failures++; $display("FAIL bootreq_cycle got fg=%b run=%b exp 1 1", fetch_gnt, running); end
    next_cycle();
    boot_req = 1'b0; fetch_addr = 13'd1;
    @(negedge clk);
    checks++; if (running !== 1'b0 || fetch_gnt !== 1'b0 || load_count !== '0) begin failures++; $display("FAIL bootreq_entry got run=%b fg=%b cnt=%0d exp 0 0 0", running, fetch_gnt, load_count); end
    checks++; if (fetch_valid !== 1'b1 || fetch_inst !== 32'h20080005) begin failures++; $display("FAIL bootreq_inflight got v=%b inst=%h exp 1 20080005", fetch_valid, fetch_inst); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_saturate();
    load_req = 1'b1;
    for (int i = 0; i < DEPTH + 8; i++) begin
      load_addr = ADDR_W'(i); load_data = $urandom;
      @(negedge clk);
      if (i == DEPTH - 1) begin
        checks++; if (load_count !== 14'(DEPTH - 1)) begin failures++; $display("FAIL count_before_sat got %0d exp %0d", load_count, DEPTH - 1); end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (load_count !== 14'(DEPTH)) begin failures++; $display("FAIL count_saturate got %0d exp %0d", load_count, DEPTH); end
    load_done = 1'b1;
    next_cycle();
    load_done = 1'b0;
    @(negedge clk);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL rerun got %b exp 1", running); end
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1; fetch_addr = 13'd2;
    @(negedge clk);
    checks++; if (fetch_gnt !== 1'b1) begin failures++; $display("FAIL midrst_fetch got %b exp 1", fetch_gnt); end
    next_cycle();
    reset = 1'b1; load_req = 1'b1; load_addr = 13'd200; load_data = 32'h12345678;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || fetch_gnt !== 1'b0 || load_gnt !== 1'b0) begin failures++; $display("FAIL midrst_grants got we=%b fg=%b lg=%b exp 0 0 0", mem_we, fetch_gnt, load_gnt); end
    next_cycle();
    reset = 1'b0; idle_inputs();
    @(negedge clk);
    checks++; if (fetch_valid !== 1'b0 || fetch_inst !== '0 || running !== 1'b0 || load_count !== '0) begin failures++; $display("FAIL midrst_after got v=%b inst=%h run=%b cnt=%0d exp 0 0 0 0", fetch_valid, fetch_inst, running, load_count); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 63) == 0);
      fetch_req  = ($urandom_range(0, 3) != 0);
      fetch_addr = ADDR_W'($urandom_range(0, 15));
      load_req   = ($urandom_range(0, 3) != 0);
      load_addr  = ADDR_W'($urandom_range(0, 15));
      load_data  = $urandom;
      load_done  = ($urandom_range(0, 15) == 0);
      boot_req   = ($urandom_range(0, 23) == 0);
      @(negedge clk);
      e_addr  = exp_lg ? load_addr : (exp_fg ? fetch_addr : '0);
      e_wdata = exp_lg ? load_data : '0;
      checks++; if (fetch_gnt !== exp_fg || load_gnt !== exp_lg || mem_we !== exp_lg) begin failures++; $display("FAIL rnd_grant cyc=%0d got fg=%b lg=%b we=%b exp %b %b %b", c, fetch_gnt, load_gnt, mem_we, exp_fg, exp_lg, exp_lg); end
      checks++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin failures++; $display("FAIL rnd_mux cyc=%0d got a=%0d d=%h exp %0d %h", c, mem_addr, mem_wdata, e_addr, e_wdata); end
      checks++; if (fetch_valid !== m_valid || fetch_inst !== m_inst) begin failures++; $display("FAIL rnd_read cyc=%0d got v=%b inst=%h exp %b %h", c, fetch_valid, fetch_inst, m_valid, m_inst); end
      checks++; if (running !== m_run || load_count !== 14'(m_count)) begin failures++; $display("FAIL rnd_status cyc=%0d got run=%b cnt=%0d exp %b %0d", c, running, load_count, m_run, m_count); end
      next_cycle();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_boot_load();
    test_starve();
    test_load_idle();
    test_boot_req();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Single-port access controller for the pipeline's instruction memory, sitting between the IF stage, the program loader and the memory array. After reset it owns the memory for the loader (boot phase) and blocks fetch. Once loading completes it gives the fetch stage priority and interleaves late loader writes under a bounded-starvation rule. It also counts words written so software and the testbench can check program size.

## Interface
- ADDR_W, 13, instruction-memory word-address width (8192 words)
- DATA_W, 32, instruction width
- STARVE_MAX, 4, maximum consecutive denied cycles for a pending loader write in RUN (≥1)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- fetch_req  in  1  IF stage requests a read this cycle
- fetch_addr  in  ADDR_W  word address (PC) to read
- fetch_gnt  out  1  read issued to memory this cycle (combinational)
- fetch_valid  out  1  registered; high the cycle after a fetch_gnt
- fetch_inst  out  DATA_W  mem_rdata when fetch_valid, else 0
- load_req  in  1  loader has a write pending
- load_addr  in  ADDR_W  write address
- load_data  in  DATA_W  write data
- load_gnt  out  1  write issued this cycle (combinational); loader advances on it
- load_done  in  1  single-cycle pulse: program complete
- boot_req  in  1  single-cycle pulse: re-enter boot phase for reprogramming
- running  out  1  registered; high in RUN only
- load_count  out  ADDR_W+1  registered count of granted writes since last boot entry
- mem_addr  out  ADDR_W  memory address (combinational mux)
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous-read data, valid one cycle after mem_addr

## Operation
- States: BOOT, RUN. Reset → BOOT.
- BOOT: fetch_gnt=0 always. load_gnt=load_req. load_done → RUN next cycle (a write granted in the same cycle completes). boot_req ignored.
- RUN: default fetch_gnt=fetch_req, load_gnt=load_req & ~fetch_req. Starvation: starve_cnt increments each cycle load_req=1 and load_gnt=0; when starve_cnt==STARVE_MAX and load_req=1, loader is granted, fetch_gnt=0 that cycle, starve_cnt cleared. starve_cnt also clears on any load_gnt or when load_req=0. load_done ignored.
- RUN + boot_req → BOOT next cycle; a grant in the boot_req cycle still follows RUN rules; load_count and starve_cnt clear on entry to BOOT.
- Mux: load_gnt → mem_addr=load_addr, mem_we=1, mem_wdata=load_data; fetch_gnt → mem_addr=fetch_addr, mem_we=0; neither → mem_addr=0, mem_we=0, mem_wdata=0. fetch_gnt and load_gnt are never high together.
- load_count increments on each load_gnt; saturates at 2^ADDR_W.
- Address arithmetic is plain ADDR_W-bit; no wrap/range checking (full address space valid).

## Timing
- Reset (while high and the cycle after): state=BOOT, fetch_valid=0, fetch_inst=0, running=0, load_count=0, starve_cnt=0; combinational grants forced 0, mem_we=0.
- Reset mid-operation: in-flight fetch is dropped (fetch_valid=0 next cycle), no write issued in the reset cycle.
- Read latency: fetch_gnt at cycle N → fetch_valid, fetch_inst at N+1. Back-to-back fetches at full rate.
- Write: committed at the rising edge ending the load_gnt cycle; readable by a fetch granted the next cycle.
- Worst-case loader wait in RUN: STARVE_MAX denied cycles, granted on cycle STARVE_MAX+1.
- IF stage must hold fetch_addr and fetch_req while fetch_gnt=0; loader must hold load_* while load_gnt=0.

## Structure
- Package imem_pkg: state enum (BOOT, RUN), ADDR_W/DATA_W defaults, STARVE_MAX default.
- One sub-module natural: imem_starve_ctr (counter, clear, saturation-compare output) instantiated once.
- Memory array stays external; this block contains no storage beyond control registers.

## Test plan
- Reset then fetch_req=1 with load_req=0 for 10 cycles → fetch_gnt=0 throughout, running=0, fetch_valid=0.
- BOOT: 3 writes to addr 0,1,2 (data 0x20080005, 0x20090003, 0x01095020), load_done on 3rd → load_count=3, running=1 next cycle; fetch addr 0,1,2 → fetch_inst in that order, one cycle after each grant.
- RUN, fetch_req held high, load_req held high from cycle 0 (STARVE_MAX=4) → load_gnt=0 cycles 0–3, load_gnt=1 and fetch_gnt=0 at cycle 4, pattern repeats every 5 cycles.
- RUN, fetch_req low, load_req high → load_gnt=1 same cycle, mem_we=1, starve_cnt stays 0.
- boot_req during RUN with fetch stream → BOOT next cycle, fetch_gnt=0, load_count=0, last granted fetch still returns fetch_valid=1.
- reset asserted the cycle after a fetch_gnt and concurrent load_req → fetch_valid=0, mem_we=0, state BOOT, load_count=0.
